// File: rtl/usb_sof_tracker.sv
// USB SOF tracker: locks onto host frame timing, emits one tick per frame and
// synthesizes ticks across missed SOFs. Define SOF_TRACKER_IIR_EN for IIR period smoothing.
module usb_sof_tracker #(
  parameter int NOMINAL  = 48000,
  parameter int TOL      = 240,
  parameter int MISS_MAX = 3,
  parameter int PW       = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          sof_in,
  input  logic          clr,
  output logic          tick,
  output logic          tick_synth,
  output logic          locked,
  output logic          lost,
  output logic [PW-1:0] period,
  output logic [10:0]   frame_cnt,
  output logic [7:0]    miss_total
);

  localparam logic [PW-1:0] WIN_LO  = PW'((NOMINAL > TOL) ? NOMINAL - TOL : 0);
  localparam logic [PW-1:0] WIN_HI  = PW'(NOMINAL + TOL);
  localparam logic [PW:0]   TOL_W   = (PW+1)'(TOL);
  localparam logic [PW-1:0] CNT_PH  = PW'(TOL + 1);
  localparam logic [PW-1:0] CNT_ONE = PW'(1);
  localparam logic [3:0]    RUN_MAX = 4'(MISS_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_TRACK, S_HOLD} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] cnt, cnt_nx, cnt_inc;
  logic [PW-1:0] period_nx, period_upd;
  logic [PW:0]   deadline;
  logic [3:0]    run, run_nx, run_inc;
  logic          first, first_nx;
  logic          tick_nx, synth_nx, lost_nx;
  logic          in_win, sof_ok, dl_hit;

  assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_ONE;
  assign in_win   = (cnt >= WIN_LO) && (cnt <= WIN_HI);
  assign sof_ok   = sof_in && in_win;
  assign deadline = {1'b0, period} + TOL_W;
  // A valid SOF landing on the deadline cycle wins over the synthesized tick.
  assign dl_hit   = ({1'b0, cnt} >= deadline) && !sof_ok;
  assign run_inc  = (state == S_TRACK) ? 4'd1 : run + 4'd1;

`ifdef SOF_TRACKER_IIR_EN
  assign period_upd = PW'(({2'b00, period} + {1'b0, period, 1'b0} + {2'b00, cnt}
                          + (PW+2)'(2)) >> 2);
`else
  assign period_upd = cnt;
`endif

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt_inc;
    period_nx = period;
    run_nx    = run;
    first_nx  = first;
    tick_nx   = 1'b0;
    synth_nx  = 1'b0;
    lost_nx   = 1'b0;
    if (!enable) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      run_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_ACQ;
          cnt_nx   = '0;
          first_nx = 1'b1;
        end
        S_ACQ: begin
          if (sof_in) begin
            tick_nx  = 1'b1;
            cnt_nx   = CNT_ONE;
            first_nx = 1'b0;
            if (!first && in_win) begin
              period_nx = cnt;
              run_nx    = '0;
              state_nx  = S_TRACK;
            end
          end
        end
        default: begin
          if (sof_ok) begin
            tick_nx   = 1'b1;
            cnt_nx    = CNT_ONE;
            period_nx = period_upd;
            run_nx    = '0;
            state_nx  = S_TRACK;
          end else if (dl_hit) begin
            // Reloading TOL+1 keeps the synthesized frame on the nominal phase.
            tick_nx  = 1'b1;
            synth_nx = 1'b1;
            cnt_nx   = CNT_PH;
            run_nx   = run_inc;
            state_nx = S_HOLD;
            if (run_inc >= RUN_MAX) begin
              lost_nx  = 1'b1;
              state_nx = S_ACQ;
              cnt_nx   = '0;
              run_nx   = '0;
              first_nx = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      run        <= '0;
      first      <= 1'b0;
      period     <= PW'(NOMINAL);
      tick       <= 1'b0;
      tick_synth <= 1'b0;
      lost       <= 1'b0;
      frame_cnt  <= '0;
      miss_total <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      run        <= run_nx;
      first      <= first_nx;
      period     <= period_nx;
      tick       <= tick_nx;
      tick_synth <= synth_nx;
      lost       <= lost_nx;
      if (tick_nx)
        frame_cnt <= frame_cnt + 11'd1;
      if (clr)
        miss_total <= '0;
      else if (synth_nx && (miss_total != '1))
        miss_total <= miss_total + 8'd1;
    end
  end

  assign locked = (state == S_TRACK) || (state == S_HOLD);

endmodule

// File: tb/tb_usb_sof_tracker.sv
// Randomized self-checking bench for usb_sof_tracker against a time-anchor
// reference model; a second small instance exercises frame_cnt wrap-around.
`timescale 1ns/1ps
module tb_usb_sof_tracker;

  localparam int N  = 500;
  localparam int T  = 20;
  localparam int MM = 3;
  localparam int PW = 10;

  logic clk = 1'b0;
  logic rst_n, enable = 1'b0, sof_in = 1'b0, clr = 1'b0;
  logic tick, tick_synth, locked, lost;
  logic [PW-1:0] period;
  logic [10:0]   frame_cnt;
  logic [7:0]    miss_total;

  logic rst2_n, en2 = 1'b0, sof2 = 1'b0;
  logic tick2, synth2, locked2, lost2;
  logic [3:0]  per2;
  logic [10:0] fc2;
  logic [7:0]  mt2;

  usb_sof_tracker #(.NOMINAL(N), .TOL(T), .MISS_MAX(MM), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sof_in(sof_in), .clr(clr),
    .tick(tick), .tick_synth(tick_synth), .locked(locked), .lost(lost),
    .period(period), .frame_cnt(frame_cnt), .miss_total(miss_total)
  );

  usb_sof_tracker #(.NOMINAL(12), .TOL(1), .MISS_MAX(MM), .PW(4)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .enable(en2), .sof_in(sof2), .clr(1'b0),
    .tick(tick2), .tick_synth(synth2), .locked(locked2), .lost(lost2),
    .period(per2), .frame_cnt(fc2), .miss_total(mt2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks the time of the last frame anchor instead of a counter.
  typedef enum {M_IDLE, M_ACQ, M_TRACK, M_HOLD} mode_t;
  mode_t m_mode;
  int    m_now, m_anchor, m_per, m_misses, m_frame, m_miss;
  bit    m_first, e_tick, e_synth, e_lost;

  function automatic bit in_window(int el);
    return (el >= N - T) && (el <= N + T);
  endfunction

  function automatic int new_period(int el);
`ifdef SOF_TRACKER_IIR_EN
    return (3 * m_per + el + 2) / 4;
`else
    return el;
`endif
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_per = N; m_frame = 0; m_miss = 0; m_misses = 0;
    m_first = 1'b0; e_tick = 1'b0; e_synth = 1'b0; e_lost = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit en, input bit c);
    int el;
    bit tk = 1'b0, sy = 1'b0, ls = 1'b0;
    el = m_now - m_anchor;
    if (el > 2**PW - 1) el = 2**PW - 1;
    if (!en) begin
      m_mode = M_IDLE;
      m_misses = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_ACQ; m_anchor = m_now + 1; m_first = 1'b1;
    end else if (m_mode == M_ACQ) begin
      if (s) begin
        tk = 1'b1;
        if (!m_first && in_window(el)) begin
          m_per = el; m_mode = M_TRACK; m_misses = 0;
        end
        m_first = 1'b0; m_anchor = m_now;
      end
    end else begin
      if (s && in_window(el)) begin
        tk = 1'b1; m_per = new_period(el); m_anchor = m_now;
        m_misses = 0; m_mode = M_TRACK;
      end else if (el >= m_per + T) begin
        tk = 1'b1; sy = 1'b1;
        m_misses = (m_mode == M_TRACK) ? 1 : m_misses + 1;
        m_anchor = m_now - T; m_mode = M_HOLD;
        if (m_misses >= MM) begin
          ls = 1'b1; m_mode = M_ACQ; m_anchor = m_now + 1; m_first = 1'b1; m_misses = 0;
        end
      end
    end
    if (tk) m_frame = (m_frame + 1) % 2048;
    if (c) m_miss = 0;
    else if (sy && m_miss < 255) m_miss++;
    e_tick = tk; e_synth = sy; e_lost = ls;
    m_now++;
  endtask

  task automatic check_outputs();
    chk("tick", tick, e_tick);
    chk("tick_synth", tick_synth, e_synth);
    chk("lost", lost, e_lost);
    chk("locked", locked, (m_mode == M_TRACK || m_mode == M_HOLD));
    chk("period", period, m_per);
    chk("frame_cnt", frame_cnt, m_frame);
    chk("miss_total", miss_total, m_miss);
  endtask

  // Called at a falling edge; inputs are sampled on the next rising edge.
  task automatic step(input bit s, input bit c);
    sof_in = s; clr = c;
    @(posedge clk);
    if (rst_n) model_edge(s, enable, c);
    @(negedge clk);
    sof_in = 1'b0; clr = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic sof_after(input int g);
    idle(g - 1);
    step(1'b1, 1'b0);
  endtask

  task automatic main_seq();
    rst_n = 1'b1; enable = 1'b1;
    step(1'b0, 1'b0);
    // acquire
    sof_after(N);
    chk("acq_first_tick", tick, 1); chk("acq_first_unlocked", locked, 0);
    sof_after(N);
    chk("acq_locked", locked, 1); chk("acq_period", period, N); chk("acq_frames", frame_cnt, 2);
    // drift
    sof_after(N + 10);
`ifdef SOF_TRACKER_IIR_EN
    chk("drift_period", period, 503);
`else
    chk("drift_period", period, N + 10);
`endif
    // re-acquire to restore period = N
    enable = 1'b0;
    step(1'b0, 1'b0);
    chk("dis_unlocked", locked, 0); chk("dis_frames", frame_cnt, 3);
    step(1'b0, 1'b0);
    enable = 1'b1;
    step(1'b0, 1'b0);
    sof_after(N); sof_after(N);
    chk("reacq_period", period, N); chk("reacq_frames", frame_cnt, 5);
    // single drop
    idle(N + T);
    chk("drop_tick", tick, 1); chk("drop_synth", tick_synth, 1); chk("drop_miss", miss_total, 1);
    idle(N - T - 1);
    step(1'b1, 1'b0);
    chk("drop_real_tick", tick, 1); chk("drop_real_synth", tick_synth, 0); chk("drop_locked", locked, 1);
    // loss of lock
    idle(N + T); chk("loss_s1", tick_synth, 1);
    idle(N);     chk("loss_s2", tick_synth, 1); chk("loss_s2_locked", locked, 1);
    idle(N);     chk("loss_s3", tick_synth, 1); chk("loss_lost", lost, 1);
    chk("loss_unlocked", locked, 0); chk("loss_miss_total", miss_total, 4);
    sof_after(N); chk("relock_first", locked, 0); chk("relock_first_tick", tick, 1);
    sof_after(N); chk("relock_second", locked, 1);
    // glitch
    sof_after(50);
    chk("glitch_no_tick", tick, 0); chk("glitch_period", period, N);
    sof_after(N - 50);
    chk("glitch_next_tick", tick, 1);
    // deadline tie
    sof_after(N + T);
    chk("tie_tick", tick, 1); chk("tie_no_synth", tick_synth, 0);
    // clr against a simultaneous miss
    idle(m_per + T - 1);
    step(1'b0, 1'b1);
    chk("clr_synth", tick_synth, 1); chk("clr_miss_total", miss_total, 0);
    // enable drop in HOLD
    enable = 1'b0;
    step(1'b0, 1'b0);
    chk("hold_dis_unlocked", locked, 0); chk("hold_dis_tick", tick, 0);
    idle(40);
    // async reset mid-TRACK
    enable = 1'b1;
    step(1'b0, 1'b0);
    sof_after(N); sof_after(N + 15); idle(300);
    chk("pre_rst_locked", locked, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_period", period, N); chk("rst_locked", locked, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // randomized traffic
    for (int unsigned i = 0; i < 60; i++) begin
      int kind, g;
      kind = $urandom_range(0, 9);
      if (kind == 9) begin
        enable = 1'b0;
        idle($urandom_range(1, 5));
        enable = 1'b1;
        g = $urandom_range(N - T, N + T);
      end else if (kind <= 5) g = $urandom_range(N - T, N + T);
      else if (kind == 6) g = $urandom_range(5, N - T - 1);
      else if (kind == 7) g = $urandom_range(N + T + 1, 2 * N + T);
      else g = m_per + T;
      for (int unsigned j = 1; j < g; j++) step(1'b0, $urandom_range(0, 199) == 0);
      step(1'b1, 1'b0);
    end
  endtask

  task automatic wrap_run();
    rst2_n = 1'b1; en2 = 1'b1;
    for (int unsigned i = 0; i < 2050; i++) begin
      repeat (11) @(negedge clk);
      sof2 = 1'b1;
      @(negedge clk);
      sof2 = 1'b0;
      chk("wrap_tick", tick2, 1);
      chk("wrap_frame", fc2, (i + 1) % 2048);
    end
    chk("wrap_locked", locked2, 1);
  endtask

  initial begin
    rst_n = 1'b1; rst2_n = 1'b1;
    #1;
    rst_n = 1'b0; rst2_n = 1'b0;
    model_reset();
    m_now = 0; m_anchor = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    chk("wrap_rst_frame", fc2, 0);
    fork
      main_seq();
      wrap_run();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
